// File: rtl/sm_muldiv_pkg.sv
// Shared op codes, MIPS function-field decodes and FSM state type for the multiply/divide unit.
package sm_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } mdState_t;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; result WIDTH+1 cycles after start.
// No queueing: start and MTHI/MTLO strobes are dropped while busy, the PC stalls on busy.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             wrHi,
  input  logic             wrLo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdState_t           state;
  logic [CW-1:0]      cnt;
  logic [1:0]         opR;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   mag;
  logic [WIDTH-1:0]   aRaw;
  logic               negLo;
  logic               negHi;
  logic               zeroDiv;

  logic               signA, signB;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic [WIDTH-1:0]   quot, remOut;
  logic [2*WIDTH-1:0] prod;

  // Multiply: acc = {partial sum, remaining multiplier bits}.
  // Divide:   acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  always_comb begin
    signA    = isSignedOp(op) & srcA[WIDTH-1];
    signB    = isSignedOp(op) & srcB[WIDTH-1];
    absA     = signA ? -srcA : srcA;
    absB     = signB ? -srcB : srcB;
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag : {WIDTH{1'b0}})};
    divShift = {rem, acc[WIDTH-1]};
    // rem < divisor keeps the trial difference within WIDTH+1 signed bits
    divDiff  = divShift - {1'b0, mag};
    quot     = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remOut   = negHi ? -rem : rem;
    prod     = negLo ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            opR     <= op;
            aRaw    <= srcA;
            negLo   <= signA ^ signB;
            negHi   <= signA;
            zeroDiv <= op[1] && (srcB == '0);
            rem     <= '0;
            mag     <= op[1] ? absB : absA;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? absA : absB)};
            cnt     <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state   <= S_CALC;
          end else begin
            if (wrHi) hi <= wd;
            if (wrLo) lo <= wd;
          end
        end
        S_CALC: begin
          if (opR[1]) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~divDiff[WIDTH]};
            rem            <= divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
          end else begin
            acc <= {mulSum, acc[WIDTH-1:1]};
          end
          if (cnt == '0) state <= S_SIGN;
          else           cnt   <= cnt - CW'(1);
        end
        S_SIGN: begin
          if (opR[1] && zeroDiv) begin
            lo      <= '1;
            hi      <= aRaw;
            divZero <= 1'b1;
          end else if (opR[1]) begin
            lo <= quot;
            hi <= remOut;
          end else begin
            {hi, lo} <= prod;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_muldiv.sv
// Directed bench for sm_muldiv: transaction-level reference model checked every cycle plus literal results.
module tb_sm_muldiv;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, start, wrHi, wrLo;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA, srcB, wd;
  logic             busy, done, divZero;
  logic [WIDTH-1:0] hi, lo;

  int tests = 0;
  int fails = 0;
  bit chkEn = 1'b0;

  sm_muldiv #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .wrHi(wrHi), .wrLo(wrLo), .wd(wd), .busy(busy), .done(done),
    .divZero(divZero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural result of one operation: {divZero, hi, lo}.
  function automatic logic [64:0] refOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = ua * ub; return {1'b0, p}; end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        q = ua / ub;
        r = ua % ub;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Cycle-level reference: an accepted op yields its result WIDTH+1 edges later.
  logic        mBusy, mDone, mDz;
  logic [31:0] mHi, mLo;
  logic [64:0] pend;
  int          mLeft;

  always @(posedge clk) begin
    mDone <= 1'b0;
    mDz   <= 1'b0;
    if (rst) begin
      mBusy <= 1'b0; mHi <= '0; mLo <= '0; mLeft <= 0;
    end else if (mLeft > 1) begin
      mLeft <= mLeft - 1;
    end else if (mLeft == 1) begin
      mLeft <= 0; mBusy <= 1'b0; mDone <= 1'b1;
      {mDz, mHi, mLo} <= pend;
    end else if (start) begin
      pend  <= refOp(op, srcA, srcB);
      mLeft <= WIDTH + 1;
      mBusy <= 1'b1;
    end else begin
      if (wrHi) mHi <= wd;
      if (wrLo) mLo <= wd;
    end
  end

  always @(negedge clk) begin
    if (chkEn)
      chk("cycle_vs_model", {29'd0, busy, done, divZero, hi, lo}, {29'd0, mBusy, mDone, mDz, mHi, mLo});
  end

  // mode 0 plain, 1 start/wrHi while busy, 3 reset at cycle 10, 4 start together with wrLo
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input logic [31:0] keepLo,
                       output int lat, output bit busyOk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    lat = -1; busyOk = 1'b1;
    if (mode == 4) begin wrLo = 1'b1; wd = 32'hDEAD; end
    for (int i = 1; i <= WIDTH + 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; wrLo = 1'b0;
        srcA = ~a; srcB = b + 32'd1; op = ~o;
        if (mode == 4) chk("start_wrlo_dropped", {64'd0, lo}, {64'd0, keepLo});
      end
      if (mode == 1 && i == 5) begin start = 1'b1; op = 2'b01; srcA = 32'd3; srcB = 32'd4; end
      if (mode == 1 && i == 6) start = 1'b0;
      if (mode == 1 && i == 8) begin wrHi = 1'b1; wd = 32'hBAD0; end
      if (mode == 1 && i == 9) wrHi = 1'b0;
      if (mode == 3 && i == 10) rst = 1'b1;
      if (mode == 3 && i == 11) begin
        rst = 1'b0;
        chk("reset_mid_op", {30'd0, busy, done, hi, lo}, 96'd0);
      end
      if (done && lat < 0) begin
        lat = i - 1;
        if (mode != 3) break;
      end
      if (lat < 0 && i <= WIDTH + 1 && !busy) busyOk = 1'b0;
    end
  endtask

  int lat;
  bit bOk;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    wrHi = 1'b0; wrLo = 1'b0; wd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {29'd0, busy, done, divZero, hi, lo}, 96'd0);
    chkEn = 1'b1;

    chk("model_multu", 96'(refOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF)), {32'd0, 1'b0, 32'hFFFFFFFE, 32'h00000001});
    chk("model_mult",  96'(refOp(2'b00, 32'hFFFFFFFD, 32'd7)),        {32'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
    chk("model_div",   96'(refOp(2'b10, 32'hFFFFFFF9, 32'd2)),        {32'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model_divmn", 96'(refOp(2'b10, 32'h80000000, 32'hFFFFFFFF)), {32'd0, 1'b0, 32'h00000000, 32'h80000000});
    chk("model_div0",  96'(refOp(2'b11, 32'd5, 32'd0)),               {32'd0, 1'b1, 32'h00000005, 32'hFFFFFFFF});

    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd0, lat, bOk);
    chk("multu_latency", lat, 33);
    chk("multu_busy_held", {95'd0, bOk}, 96'd1);
    chk("multu_result", {32'd0, hi, lo}, {32'd0, 32'hFFFFFFFE, 32'h00000001});

    runOp(2'b00, 32'hFFFFFFFD, 32'd7, 0, 32'd0, lat, bOk);
    chk("mult_neg", {32'd0, hi, lo}, {32'd0, 32'hFFFFFFFF, 32'hFFFFFFEB});
    runOp(2'b00, 32'h80000000, 32'h80000000, 0, 32'd0, lat, bOk);
    chk("mult_minmin", {32'd0, hi, lo}, {32'd0, 32'h40000000, 32'h00000000});

    runOp(2'b11, 32'd100, 32'd7, 0, 32'd0, lat, bOk);
    chk("divu_100_7", {32'd0, hi, lo}, {32'd0, 32'd2, 32'd14});
    runOp(2'b10, 32'hFFFFFFF9, 32'd2, 0, 32'd0, lat, bOk);
    chk("div_m7_2", {32'd0, hi, lo}, {32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    runOp(2'b10, 32'd7, 32'hFFFFFFFE, 0, 32'd0, lat, bOk);
    chk("div_7_m2", {32'd0, hi, lo}, {32'd0, 32'h00000001, 32'hFFFFFFFD});

    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0, lat, bOk);
    chk("div_min_m1", {32'd0, hi, lo}, {32'd0, 32'h00000000, 32'h80000000});
    runOp(2'b11, 32'd5, 32'd0, 0, 32'd0, lat, bOk);
    chk("divu_by_zero", {31'd0, divZero, hi, lo}, {31'd0, 1'b1, 32'd5, 32'hFFFFFFFF});
    chk("divu_by_zero_latency", lat, 33);
    runOp(2'b10, 32'hFFFFFFFB, 32'd0, 0, 32'd0, lat, bOk);
    chk("div_by_zero", {31'd0, divZero, hi, lo}, {31'd0, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF});

    runOp(2'b01, 32'h00010000, 32'h00030005, 1, 32'd0, lat, bOk);
    chk("ignore_start_wrhi", {32'd0, hi, lo}, {32'd0, 32'h00000003, 32'h00050000});
    chk("ignore_start_latency", lat, 33);

    @(negedge clk);
    wrLo = 1'b1; wd = 32'h1234;
    @(negedge clk);
    wrLo = 1'b0;
    chk("mtlo_idle", {32'd0, hi, lo}, {32'd0, 32'h00000003, 32'h00001234});

    runOp(2'b01, 32'd6, 32'd7, 4, 32'h00001234, lat, bOk);
    chk("start_wrlo_result", {32'd0, hi, lo}, {32'd0, 32'd0, 32'd42});

    runOp(2'b10, 32'hFFFFFF9C, 32'd7, 3, 32'd0, lat, bOk);
    chk("reset_no_done", lat, -1);
    runOp(2'b11, 32'd9, 32'd3, 0, 32'd0, lat, bOk);
    chk("divu_after_reset", {32'd0, hi, lo}, {32'd0, 32'd0, 32'd3});

    @(negedge clk);
    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
